// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Works on one operand bit per cycle and applies sign correction in the final cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } stateT;

  stateT state;
  stateT stateNext;

  logic [CW-1:0]     bitCount;
  logic              isDiv;
  logic              negResult;
  logic              negRem;
  logic              divZero;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  logic              startAccept;
  logic              lastBit;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   aMag;
  logic [XLEN-1:0]   bMag;
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic [XLEN:0]     divDiff;
  logic              divFits;
  logic [2*XLEN-1:0] prodFinal;
  logic [XLEN-1:0]   quotFinal;
  logic [XLEN-1:0]   remFinal;

  assign startAccept = (state == IDLE) && start && !flush;
  assign lastBit     = (bitCount == LAST_COUNT);

  // Signed ops run on magnitudes; the result signs are remembered for FIN.
  assign aNeg = op[0] & a[XLEN-1];
  assign bNeg = op[0] & b[XLEN-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;

  assign mulSum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});

  // Trial subtraction on the XLEN+1-bit partial remainder; its sign bit says whether it fit.
  assign divShift = {rem, acc[XLEN-1]};
  assign divDiff  = divShift - {1'b0, operand};
  assign divFits  = ~divDiff[XLEN];

  assign prodFinal = negResult ? -acc : acc;
  assign quotFinal = divZero ? {XLEN{1'b1}} : (negResult ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign remFinal  = negRem ? -rem : rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (startAccept) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (lastBit) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIN);
    done = (state == FIN) && !flush;
  end

  // For divide the low half of acc holds the dividend and shifts in quotient bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCount  <= '0;
      isDiv     <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      rem       <= '0;
    end else if (startAccept) begin
      bitCount  <= '0;
      isDiv     <= op[1];
      negResult <= aNeg ^ bNeg;
      negRem    <= aNeg;
      divZero   <= (b == '0);
      rem       <= '0;
      if (op[1]) begin
        operand <= bMag;
        acc     <= {{XLEN{1'b0}}, aMag};
      end else begin
        operand <= aMag;
        acc     <= {{XLEN{1'b0}}, bMag};
      end
    end else if ((state == RUN) && !flush) begin
      bitCount <= bitCount + 1'b1;
      if (isDiv) begin
        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], divFits};
        rem <= divFits ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
      end else begin
        acc <= {mulSum, acc[XLEN-1:1]};
      end
    end
  end

  // HI/LO change only on a completed operation or an idle-state write not overridden by start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == FIN) && !flush) begin
      if (isDiv) begin
        hi <= remFinal;
        lo <= quotFinal;
      end else begin
        hi <= prodFinal[2*XLEN-1:XLEN];
        lo <= prodFinal[XLEN-1:0];
      end
    end else if ((state == IDLE) && !startAccept) begin
      if (wr_hi) begin
        hi <= wdata;
      end
      if (wr_lo) begin
        lo <= wdata;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and HI/LO width; legal values are even and >= 4.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  XLEN  multiplicand or dividend; captured with start.
REQ-007 b  input  XLEN  multiplier or divisor; captured with start.
REQ-008 flush  input  1  abort any in-flight operation.
REQ-009 wr_hi  input  1  MTHI strobe: load HI from wdata.
REQ-010 wr_lo  input  1  MTLO strobe: load LO from wdata.
REQ-011 wdata  input  XLEN  data for wr_hi and wr_lo.
REQ-012 busy  output  1  operation in flight; the E-stage stall source.
REQ-013 done  output  1  one-cycle pulse in the final cycle of an operation.
REQ-014 hi  output  XLEN  HI register: product upper half or remainder.
REQ-015 lo  output  XLEN  LO register: product lower half or quotient.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and FIN, and SHALL be registered.
REQ-017 IDLE with start=1 and flush=0: SHALL capture a, b and op and go to RUN.
REQ-018 On capture, signed ops SHALL convert both operands to magnitudes and record the result signs.
REQ-019 RUN SHALL process exactly one operand bit per cycle for XLEN cycles, then go to FIN.
REQ-020 Multiply SHALL use shift-add on a 2*XLEN accumulator.
REQ-021 Divide SHALL use restoring shift-subtract with an XLEN+1-bit partial remainder.
REQ-022 FIN SHALL apply sign correction, assert done, load hi and lo at the closing edge, then go to IDLE.
REQ-023 Latency: start is sampled at edge 0; busy=1 in cycles 1..XLEN+1; done=1 only in cycle XLEN+1; the new hi and lo are visible from cycle XLEN+2.
REQ-024 busy SHALL be 1 exactly when the state is RUN or FIN, and 0 in IDLE.
REQ-025 MULT SHALL produce the two's-complement 2*XLEN product, with hi holding the upper half and lo the lower half.
REQ-026 DIV quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-027 Divide by zero (DIVU or DIV): lo SHALL be all ones, hi SHALL equal a, and done SHALL pulse at normal latency.
REQ-028 DIV of -2^(XLEN-1) by -1: lo SHALL be -2^(XLEN-1) and hi SHALL be 0, with no exception.
REQ-029 start while busy=1 SHALL be ignored, with no queuing.
REQ-030 flush in RUN or FIN SHALL force IDLE at the next edge.
REQ-031 On flush, done SHALL stay 0 in that cycle and hi and lo SHALL be unchanged.
REQ-032 flush in IDLE SHALL block a coincident start.
REQ-033 wr_hi and wr_lo SHALL take effect only in IDLE, at the next edge, and both may be asserted in the same cycle.
REQ-034 wr_hi and wr_lo while busy=1 SHALL be ignored.
REQ-035 IDLE with start and wr_hi or wr_lo both asserted: start SHALL win and the write SHALL be dropped.
REQ-036 hi and lo SHALL change only in FIN or on an accepted write.

Reset
REQ-037 While reset=0: state IDLE; busy=0, done=0, hi=0, lo=0; all internal accumulators 0.
REQ-038 Reset asserted mid-operation SHALL discard the operation immediately, with no done pulse.
REQ-039 After reset is released, start SHALL be accepted at the first posedge.

Verification
REQ-040 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 33; then hi=0xFFFFFFFE, lo=0x00000001.
REQ-041 MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-042 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-043 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, at normal latency.
REQ-044 start at edge 0, flush in cycle 10 -> busy=0 from cycle 11, no done, hi and lo unchanged; a start in cycle 11 is accepted.
REQ-045 XLEN=8, DIV a=0x80, b=0xFF -> lo=0x80, hi=0x00, done in cycle 9; wr_lo in cycle 3 is ignored.
